bridge_1xn: RTL and testbench
=============================

Name: bridge_1xn

Overview:
- Parametrised 1-master, NSLV-slave data-bus bridge.
- Sits between the CPU data port and the SoC data slaves (data SRAM, confreg, further peripherals).
- Decodes each request against per-slave base/mask windows and forwards it to one slave. Allows one outstanding transaction and routes the response back.
- Unmapped addresses and slave timeouts return an error response instead of hanging the CPU.

Parameters:
XLEN, 32, data/address width.
NSLV, 2, number of slaves (>=1).
SLV_BASE, {32'hffff_0000, 32'h0000_0000}, NSLV*XLEN packed; slave i base at [i*XLEN +: XLEN].
SLV_MASK, {32'hffff_0000, 32'h8000_0000}, NSLV*XLEN packed; slave i hits when (addr & mask_i) == base_i.
TIMEOUT, 255, cycles to wait for slv_rvalid before returning an error; 0 disables the timeout.
ERR_RDATA, 32'hdead_beef, rdata returned on an error response.

Ports:
clk  input  1  clock.
reset  input  1  synchronous active-high reset.
cpu_data_req  input  1  request valid; held until cpu_data_gnt.
cpu_data_wen  input  4  byte write enables; 0 = read.
cpu_data_addr  input  XLEN  address.
cpu_data_wdata  input  XLEN  write data.
cpu_data_gnt  output  1  request accepted this cycle.
cpu_data_rvalid  output  1  response valid, 1-cycle pulse, for reads and writes.
cpu_data_rdata  output  XLEN  read data; valid only with rvalid.
cpu_data_err  output  1  response is an error (decode miss or timeout); qualified by rvalid.
slv_en  output  NSLV  per-slave request.
slv_wen  output  4*NSLV  per-slave byte enables, zero when that slave's slv_en is low.
slv_addr  output  XLEN  shared address, = cpu_data_addr.
slv_wdata  output  XLEN  shared write data, = cpu_data_wdata.
slv_gnt  input  NSLV  slave accepts request.
slv_rvalid  input  NSLV  slave response pulse (reads and writes).
slv_rdata  input  NSLV*XLEN  slave read data.

Behaviour:
- Decode is combinational. Hit index = lowest i that matches; miss = no slave matches.
- Clock and reset: one clock; reset is synchronous and active-high; ports are named clk and reset.
- FSM states: IDLE, WAIT, ERR. Registers: state, sel_r (clog2 width, min 1), timeout counter.
- Reset: state = IDLE, sel_r = 0, counter = 0.
  - While reset is high: slv_en = 0, cpu_data_gnt = 0, cpu_data_rvalid = 0, cpu_data_err = 0, cpu_data_rdata = 0.
- IDLE, req with hit i:
  - slv_en[i] = 1 and slv_wen[i] = cpu_data_wen; cpu_data_gnt = slv_gnt[i].
  - On gnt: sel_r <= i, counter <= 0, state -> WAIT. Without gnt: stay in IDLE, request held.
- IDLE, req with miss: slv_en = 0, cpu_data_gnt = 1, state -> ERR.
- IDLE, no req: all slv_en = 0.
- WAIT:
  - slv_en = 0 and cpu_data_gnt = 0; new requests are stalled.
  - If slv_rvalid[sel_r]: cpu_data_rvalid = 1, cpu_data_rdata = slv_rdata[sel_r], err = 0, state -> IDLE. This path is combinational, zero added latency.
  - Else counter++. When TIMEOUT != 0 and counter == TIMEOUT-1: state -> ERR.
  - slv_rvalid from slaves other than sel_r is ignored.
- ERR: one cycle with cpu_data_rvalid = 1, cpu_data_err = 1, cpu_data_rdata = ERR_RDATA; slv_en = 0, gnt = 0; state -> IDLE.
- A late slv_rvalid arriving after a timeout, or in IDLE/ERR, is ignored.
- Latency:
  - Hit with a 1-cycle slave: gnt in cycle 0, rvalid in cycle 1.
  - Miss: gnt in cycle 0, error response in cycle 1.
  - Next request can be granted no earlier than the cycle after the response, so peak throughput is 1 transaction per 2 cycles.
- Reset mid-transaction: any outstanding transaction is dropped with no response, and the bridge returns to IDLE.
- cpu_data_rdata is 0 whenever rvalid = 0.

Test Plan:
- Read 0x0000_0010, slave0 gnt=1 immediately and rvalid next cycle with 0x1234_5678 -> slv_en=2'b01 in cycle 0, rvalid=1 with rdata 0x1234_5678 and err=0 in cycle 1.
- Write addr 0xffff_f000 with wen 4'hf and wdata 0xa5a5_a5a5; slave1 delays gnt 3 cycles -> slv_en=2'b10 and slv_wen[7:4]=4'hf held 3 cycles; gnt on cycle 3; rvalid follows the slave's response.
- Read 0x9000_0000 (unmapped) -> gnt=1 in cycle 0, slv_en=0, cycle 1 rvalid=1, err=1, rdata=0xdead_beef.
- TIMEOUT=4, slave0 never responds -> error response exactly 4 cycles after WAIT entry. A later slave0 rvalid is ignored, and the next request decodes normally.
- Overlap check: SLV_MASK0=0, SLV_BASE0=0 (matches everything) with address 0xffff_0004 -> slave0 selected (lowest index wins).
- Reset asserted during WAIT -> outputs forced to 0, state IDLE. A slave rvalid in the following cycle produces no cpu_data_rvalid.

Source files
------------

// File: rtl/bridge_1xn.sv
// bridge_1xn: single-master to NSLV-slave data-bus bridge.
// Decodes each CPU request against per-slave base/mask windows and forwards
// it to the lowest-index matching slave. One transaction is in flight at a
// time. Decode misses and slave timeouts return an error response, so the CPU
// never waits forever.
module bridge_1xn #(
   parameter int                     XLEN      = 32,
   parameter int                     NSLV      = 2,
   parameter logic [NSLV*XLEN-1:0]   SLV_BASE  = {32'hffff_0000, 32'h0000_0000},
   parameter logic [NSLV*XLEN-1:0]   SLV_MASK  = {32'hffff_0000, 32'h8000_0000},
   parameter int                     TIMEOUT   = 255,
   parameter logic [XLEN-1:0]        ERR_RDATA = 32'hdead_beef
) (
   input  logic                   clk,
   input  logic                   reset,
   // CPU data port
   input  logic                   cpu_data_req,
   input  logic [3:0]             cpu_data_wen,
   input  logic [XLEN-1:0]        cpu_data_addr,
   input  logic [XLEN-1:0]        cpu_data_wdata,
   output logic                   cpu_data_gnt,
   output logic                   cpu_data_rvalid,
   output logic [XLEN-1:0]        cpu_data_rdata,
   output logic                   cpu_data_err,
   // Slave side
   output logic [NSLV-1:0]        slv_en,
   output logic [4*NSLV-1:0]      slv_wen,
   output logic [XLEN-1:0]        slv_addr,
   output logic [XLEN-1:0]        slv_wdata,
   input  logic [NSLV-1:0]        slv_gnt,
   input  logic [NSLV-1:0]        slv_rvalid,
   input  logic [NSLV*XLEN-1:0]   slv_rdata
);

   localparam int SEL_W = (NSLV > 1) ? $clog2(NSLV) : 1;
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam bit TO_EN = (TIMEOUT != 0);
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_ERR  = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             hit;
   logic [SEL_W-1:0] hit_idx;

   // Address and write data are shared by all slaves; only slv_en is steered.
   assign slv_addr  = cpu_data_addr;
   assign slv_wdata = cpu_data_wdata;

   // Window decode: scanning from the top down leaves the lowest matching index.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int i = NSLV - 1; i >= 0; i--) begin
         if ((cpu_data_addr & SLV_MASK[i*XLEN +: XLEN]) == SLV_BASE[i*XLEN +: XLEN]) begin
            hit     = 1'b1;
            hit_idx = SEL_W'(i);
         end
      end
   end

   // State, selected slave and timeout counter registers.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      if (reset) begin
         state_q <= S_IDLE;
         sel_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic and CPU/slave handshake outputs.
   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path can
      // leave one unassigned and infer a latch.
      state_d         = state_q;
      sel_d           = sel_q;
      cnt_d           = cnt_q;
      slv_en          = '0;
      cpu_data_gnt    = 1'b0;
      cpu_data_rvalid = 1'b0;
      cpu_data_rdata  = '0;
      cpu_data_err    = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (cpu_data_req) begin
               if (hit) begin
                  slv_en       = NSLV'(1) << hit_idx;
                  cpu_data_gnt = slv_gnt[hit_idx];
                  if (slv_gnt[hit_idx]) begin
                     sel_d   = hit_idx;
                     cnt_d   = '0;
                     state_d = S_WAIT;
                  end
               end else begin
                  // Nobody owns this address: accept it and answer with an error.
                  cpu_data_gnt = 1'b1;
                  state_d      = S_ERR;
               end
            end
         end

         S_WAIT: begin
            if (slv_rvalid[sel_q]) begin
               cpu_data_rvalid = 1'b1;
               cpu_data_rdata  = slv_rdata[int'(sel_q)*XLEN +: XLEN];
               state_d         = S_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
               if (TO_EN && (cnt_q == TO_LAST)) begin
                  state_d = S_ERR;
               end
            end
         end

         S_ERR: begin
            cpu_data_rvalid = 1'b1;
            cpu_data_err    = 1'b1;
            cpu_data_rdata  = ERR_RDATA;
            state_d         = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase

      // Outputs stay quiet for the whole reset cycle, whatever the old state was.
      if (reset) begin
         slv_en          = '0;
         cpu_data_gnt    = 1'b0;
         cpu_data_rvalid = 1'b0;
         cpu_data_rdata  = '0;
         cpu_data_err    = 1'b0;
      end
   end

   // Byte enables follow the CPU only for the slave being addressed.
   always_comb begin
      slv_wen = '0;
      for (int i = 0; i < NSLV; i++) begin
         slv_wen[i*4 +: 4] = slv_en[i] ? cpu_data_wen : 4'h0;
      end
   end

endmodule

// File: tb/tb_bridge_1xn.sv
// tb_bridge_1xn: self-checking bench for bridge_1xn.
// u_dut uses the default windows with a short timeout; u_ovl has an
// all-matching slave 0 window. Each instance is held in reset while the other
// is being tested.
module tb_bridge_1xn;

   localparam int          XLEN = 32;
   localparam int          NSLV = 2;
   localparam int          TO   = 4;
   localparam logic [63:0] BASE  = {32'hffff_0000, 32'h0000_0000};
   localparam logic [63:0] MASK  = {32'hffff_0000, 32'h8000_0000};
   localparam logic [63:0] OBASE = {32'hffff_0000, 32'h0000_0000};
   localparam logic [63:0] OMASK = {32'hffff_0000, 32'h0000_0000};
   localparam logic [31:0] ERRD  = 32'hdead_beef;

   typedef struct packed {
      logic        gnt;
      logic        rvalid;
      logic        err;
      logic [31:0] rdata;
      logic [1:0]  en;
      logic [7:0]  wen;
   } obs_t;

   logic        clk = 1'b0;
   logic        rst_m, rst_o;
   logic        req;
   logic [3:0]  wen;
   logic [31:0] addr, wdata;
   logic [1:0]  sgnt, srv;
   logic [63:0] srdata;

   logic        gnt_m, rv_m, err_m, gnt_o, rv_o, err_o;
   logic [31:0] rd_m, sa_m, sw_m, rd_o, sa_o, sw_o;
   logic [1:0]  en_m, en_o;
   logic [7:0]  wen_m, wen_o;

   int n_cmp = 0;
   int n_mis = 0;

   always #5 clk = ~clk;

   bridge_1xn #(.XLEN(XLEN), .NSLV(NSLV), .SLV_BASE(BASE), .SLV_MASK(MASK),
                .TIMEOUT(TO), .ERR_RDATA(ERRD)) u_dut (
      .clk(clk), .reset(rst_m),
      .cpu_data_req(req), .cpu_data_wen(wen), .cpu_data_addr(addr), .cpu_data_wdata(wdata),
      .cpu_data_gnt(gnt_m), .cpu_data_rvalid(rv_m), .cpu_data_rdata(rd_m), .cpu_data_err(err_m),
      .slv_en(en_m), .slv_wen(wen_m), .slv_addr(sa_m), .slv_wdata(sw_m),
      .slv_gnt(sgnt), .slv_rvalid(srv), .slv_rdata(srdata));

   bridge_1xn #(.XLEN(XLEN), .NSLV(NSLV), .SLV_BASE(OBASE), .SLV_MASK(OMASK),
                .TIMEOUT(TO), .ERR_RDATA(ERRD)) u_ovl (
      .clk(clk), .reset(rst_o),
      .cpu_data_req(req), .cpu_data_wen(wen), .cpu_data_addr(addr), .cpu_data_wdata(wdata),
      .cpu_data_gnt(gnt_o), .cpu_data_rvalid(rv_o), .cpu_data_rdata(rd_o), .cpu_data_err(err_o),
      .slv_en(en_o), .slv_wen(wen_o), .slv_addr(sa_o), .slv_wdata(sw_o),
      .slv_gnt(sgnt), .slv_rvalid(srv), .slv_rdata(srdata));

   // Reference decode: first window whose masked address equals its base.
   function automatic int decode(input logic [31:0] a, input logic [63:0] b, input logic [63:0] m);
      for (int i = 0; i < NSLV; i++) begin
         if ((a & m[i*32 +: 32]) == b[i*32 +: 32]) return i;
      end
      return -1;
   endfunction

   function automatic obs_t mk(input logic g, input logic v, input logic e,
                               input logic [31:0] d, input logic [1:0] en, input logic [7:0] w);
      obs_t o;
      o.gnt = g; o.rvalid = v; o.err = e; o.rdata = d; o.en = en; o.wen = w;
      return o;
   endfunction

   function automatic obs_t obs_main();
      return mk(gnt_m, rv_m, err_m, rd_m, en_m, wen_m);
   endfunction

   function automatic obs_t obs_ovl();
      return mk(gnt_o, rv_o, err_o, rd_o, en_o, wen_o);
   endfunction

   task automatic drive(input logic r, input logic [3:0] w, input logic [31:0] a,
                        input logic [31:0] d, input logic [1:0] g, input logic [1:0] v,
                        input logic [63:0] rd);
      req = r; wen = w; addr = a; wdata = d; sgnt = g; srv = v; srdata = rd;
   endtask

   // One CPU transaction on u_dut. gdly: stall cycles before the slave grants.
   // rdly: cycles after the grant at which the slave pulses rvalid. hold keeps
   // the CPU request asserted while the bridge is busy (it must be stalled).
   task automatic do_txn(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d,
                         input int gdly, input int rdly, input logic [31:0] rdat,
                         input bit hold, input string tag);
      int          t, last, span;
      logic [1:0]  onehot, g, v;
      logic [7:0]  ew;
      logic [63:0] rd;
      obs_t        e;
      t = decode(a, BASE, MASK);
      if (t < 0) begin
         @(negedge clk);
         drive(1'b1, w, a, d, 2'($urandom), 2'($urandom), {$urandom, $urandom});
         #1;
         e = mk(1'b1, 1'b0, 1'b0, 32'h0, 2'b00, 8'h00);
         n_cmp++;
         if (obs_main() !== e) begin
            n_mis++;
            $display("FAIL %s_miss_gnt: got %h expected %h", tag, obs_main(), e);
         end
         @(negedge clk);
         drive(hold, w, a, d, 2'($urandom), 2'($urandom), {$urandom, $urandom});
         #1;
         e = mk(1'b0, 1'b1, 1'b1, ERRD, 2'b00, 8'h00);
         n_cmp++;
         if (obs_main() !== e) begin
            n_mis++;
            $display("FAIL %s_miss_err: got %h expected %h", tag, obs_main(), e);
         end
         return;
      end
      onehot = 2'b01 << t;
      ew     = {4'h0, w} << (4 * t);
      for (int k = 0; k <= gdly; k++) begin
         @(negedge clk);
         g    = 2'($urandom);
         g[t] = (k == gdly);
         drive(1'b1, w, a, d, g, 2'($urandom), {$urandom, $urandom});
         #1;
         e = mk(k == gdly, 1'b0, 1'b0, 32'h0, onehot, ew);
         n_cmp++;
         if (obs_main() !== e) begin
            n_mis++;
            $display("FAIL %s_req%0d: got %h expected %h", tag, k, obs_main(), e);
         end
         n_cmp++;
         if ({sa_m, sw_m} !== {a, d}) begin
            n_mis++;
            $display("FAIL %s_fwd: got %h expected %h", tag, {sa_m, sw_m}, {a, d});
         end
      end
      // A response later than TO cycles after the grant is replaced by an
      // error TO+1 cycles after the grant.
      last = (rdly <= TO) ? rdly : TO + 1;
      span = (rdly > last) ? rdly : last;
      for (int j = 1; j <= span; j++) begin
         @(negedge clk);
         v    = 2'($urandom);
         v[t] = (j == rdly);
         rd   = {$urandom, $urandom};
         rd[t*32 +: 32] = rdat;
         drive(hold && (j <= last), w, a, d, 2'($urandom), v, rd);
         #1;
         if (j == last)
            e = (rdly <= TO) ? mk(1'b0, 1'b1, 1'b0, rdat, 2'b00, 8'h00)
                             : mk(1'b0, 1'b1, 1'b1, ERRD, 2'b00, 8'h00);
         else
            e = mk(1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 8'h00);
         n_cmp++;
         if (obs_main() !== e) begin
            n_mis++;
            $display("FAIL %s_rsp%0d: got %h expected %h", tag, j, obs_main(), e);
         end
      end
   endtask

   task automatic test_reset();
      obs_t e;
      e = mk(1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 8'h00);
      rst_m = 1'b1;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         drive(1'b1, 4'hf, 32'h0000_0010, 32'h0, 2'b11, 2'b11, {$urandom, $urandom});
         #1;
         n_cmp++;
         if (obs_main() !== e) begin
            n_mis++;
            $display("FAIL reset_outputs: got %h expected %h", obs_main(), e);
         end
      end
      @(negedge clk);
      rst_m = 1'b0;
      drive(1'b0, 4'h0, 32'h0, 32'h0, 2'b11, 2'b11, {$urandom, $urandom});
      #1;
      n_cmp++;
      if (obs_main() !== e) begin
         n_mis++;
         $display("FAIL idle_after_reset: got %h expected %h", obs_main(), e);
      end
   endtask

   task automatic test_read_hit();
      do_txn(32'h0000_0010, 4'h0, 32'h0, 0, 1, 32'h1234_5678, 1'b0, "read_hit");
   endtask

   task automatic test_write_delayed_gnt();
      do_txn(32'hffff_f000, 4'hf, 32'ha5a5_a5a5, 3, 2, 32'h0, 1'b0, "write_dly");
   endtask

   task automatic test_miss();
      do_txn(32'h9000_0000, 4'h0, 32'h0, 0, 1, 32'h0, 1'b0, "miss");
   endtask

   task automatic test_timeout();
      do_txn(32'h0000_0020, 4'h0, 32'h0, 0, TO + 3, 32'h7777_7777, 1'b0, "timeout");
      do_txn(32'h0000_0024, 4'h0, 32'h0, 0, 1, 32'h0bad_f00d, 1'b0, "after_timeout");
   endtask

   task automatic test_back_to_back();
      do_txn(32'h0000_0100, 4'h0, 32'h0, 0, 1, 32'h1111_1111, 1'b1, "b2b0");
      do_txn(32'hffff_0100, 4'h3, 32'h2222_2222, 0, 1, 32'h0, 1'b1, "b2b1");
      do_txn(32'h8000_0000, 4'h0, 32'h0, 0, 1, 32'h0, 1'b1, "b2b2");
      do_txn(32'h0000_0104, 4'h0, 32'h0, 0, 1, 32'h3333_3333, 1'b0, "b2b3");
   endtask

   task automatic test_reset_mid_wait();
      obs_t e;
      @(negedge clk);
      drive(1'b1, 4'h0, 32'h0000_0040, 32'h0, 2'b01, 2'b00, 64'h0);
      #1;
      e = mk(1'b1, 1'b0, 1'b0, 32'h0, 2'b01, 8'h00);
      n_cmp++;
      if (obs_main() !== e) begin
         n_mis++;
         $display("FAIL rst_mid_req: got %h expected %h", obs_main(), e);
      end
      @(negedge clk);
      rst_m = 1'b1;
      drive(1'b0, 4'h0, 32'h0, 32'h0, 2'b00, 2'b01, 64'h0000_0000_1111_2222);
      #1;
      e = mk(1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 8'h00);
      n_cmp++;
      if (obs_main() !== e) begin
         n_mis++;
         $display("FAIL rst_mid_forced: got %h expected %h", obs_main(), e);
      end
      @(negedge clk);
      rst_m = 1'b0;
      drive(1'b0, 4'h0, 32'h0, 32'h0, 2'b00, 2'b01, 64'h0000_0000_3333_4444);
      #1;
      n_cmp++;
      if (obs_main() !== e) begin
         n_mis++;
         $display("FAIL rst_mid_late_rvalid: got %h expected %h", obs_main(), e);
      end
      do_txn(32'h0000_0044, 4'h0, 32'h0, 1, 2, 32'h5555_6666, 1'b0, "after_rst_mid");
   endtask

   task automatic test_overlap();
      obs_t e;
      rst_m = 1'b1;
      @(negedge clk);
      rst_o = 1'b0;
      drive(1'b1, 4'h0, 32'hffff_0004, 32'h0, 2'b10, 2'b00, 64'h0);
      #1;
      e = mk(1'b0, 1'b0, 1'b0, 32'h0, 2'b01, 8'h00);
      n_cmp++;
      if (obs_ovl() !== e) begin
         n_mis++;
         $display("FAIL ovl_sel: got %h expected %h", obs_ovl(), e);
      end
      @(negedge clk);
      drive(1'b1, 4'h0, 32'hffff_0004, 32'h0, 2'b01, 2'b00, 64'h0);
      #1;
      e = mk(1'b1, 1'b0, 1'b0, 32'h0, 2'b01, 8'h00);
      n_cmp++;
      if (obs_ovl() !== e) begin
         n_mis++;
         $display("FAIL ovl_gnt: got %h expected %h", obs_ovl(), e);
      end
      @(negedge clk);
      drive(1'b0, 4'h0, 32'h0, 32'h0, 2'b00, 2'b10, 64'h9999_9999_0000_0000);
      #1;
      e = mk(1'b0, 1'b0, 1'b0, 32'h0, 2'b00, 8'h00);
      n_cmp++;
      if (obs_ovl() !== e) begin
         n_mis++;
         $display("FAIL ovl_other_rvalid: got %h expected %h", obs_ovl(), e);
      end
      @(negedge clk);
      drive(1'b0, 4'h0, 32'h0, 32'h0, 2'b00, 2'b01, 64'h9999_9999_cafe_0004);
      #1;
      e = mk(1'b0, 1'b1, 1'b0, 32'hcafe_0004, 2'b00, 8'h00);
      n_cmp++;
      if (obs_ovl() !== e) begin
         n_mis++;
         $display("FAIL ovl_rsp: got %h expected %h", obs_ovl(), e);
      end
      @(negedge clk);
      rst_o = 1'b1;
      rst_m = 1'b0;
      drive(1'b0, 4'h0, 32'h0, 32'h0, 2'b00, 2'b00, 64'h0);
   endtask

   task automatic test_random();
      logic [31:0] a;
      for (int n = 0; n < 40; n++) begin
         case ($urandom_range(0, 2))
            0:       a = {1'b0, 31'($urandom)};
            1:       a = {16'hffff, 16'($urandom)};
            default: a = {1'b1, 15'($urandom_range(0, 32'h7ffe)), 16'($urandom)};
         endcase
         do_txn(a, 4'($urandom), $urandom, $urandom_range(0, 3), $urandom_range(1, 7),
                $urandom, 1'($urandom), $sformatf("rnd%0d", n));
      end
   endtask

   initial begin
      rst_m = 1'b1;
      rst_o = 1'b1;
      drive(1'b0, 4'h0, 32'h0, 32'h0, 2'b00, 2'b00, 64'h0);
      repeat (2) @(posedge clk);
      test_reset();
      test_read_hit();
      test_write_delayed_gnt();
      test_miss();
      test_timeout();
      test_back_to_back();
      test_reset_mid_wait();
      test_overlap();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
